// File: rtl/vga_fb_scanner.sv
// Display-side reader of the 40x30 cell framebuffer: 640x480@60Hz timing generator,
// framebuffer read addressing and registered RRRGGGBB pixel / sync outputs.
module vga_fb_scanner #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [10:0] FB_ADDR,
    input  logic [7:0]  FB_DATA,
    output logic [7:0]  VGA_RGB,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        ACTIVE,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic       pix_tick;
    logic [9:0] h_cnt_reg;
    logic [9:0] v_cnt_reg;
    logic       vis;
    logic       hs_zone;
    logic       vs_zone;

    logic [7:0] rgb_reg;
    logic       hs_reg;
    logic       vs_reg;
    logic       active_reg;
    logic       frame_start_reg;

    // With no division every clock is a pixel, so the divider disappears entirely.
    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_tick = 1'b1;
        end else begin : g_div
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] div_cnt_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    div_cnt_reg <= '0;
                end else if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_reg <= '0;
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end

            assign pix_tick = (div_cnt_reg == DIV_LAST);
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_tick) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 1'b1;
            end
        end
    end

    assign vis     = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign hs_zone = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
    assign vs_zone = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);

    // Each cell is 16x16 pixels, so the cell coordinates are the counters shifted by 4.
    assign FB_ADDR = vis ? {v_cnt_reg[8:4], h_cnt_reg[9:4]} : 11'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rgb_reg         <= 8'h00;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= pix_tick && (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
            if (pix_tick) begin
                rgb_reg    <= vis ? FB_DATA : 8'h00;
                active_reg <= vis;
                hs_reg     <= ~hs_zone;
                vs_reg     <= ~vs_zone;
            end
        end
    end

    assign VGA_RGB     = rgb_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign ACTIVE      = active_reg;
    assign FRAME_START = frame_start_reg;

endmodule
